// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: walks a 4:1 mux select, settles on each channel,
// samples y_in and emits the assembled 4-bit word with a valid pulse.
module mux_scan_ctrl #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       cont,
    input  logic       y_in,
    output logic [1:0] sel,
    output logic       busy,
    output logic [3:0] dout,
    output logic       valid
);

    localparam logic [7:0] LP_CNT_LAST = 8'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_nxt;
    logic [1:0] r_sel;
    logic [1:0] w_sel_nxt;
    logic [2:0] r_shadow;
    logic [2:0] w_shadow_nxt;
    logic [3:0] r_dout;
    logic [3:0] w_dout_nxt;
    logic       r_valid;
    logic       w_valid_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_sel    <= '0;
            r_shadow <= '0;
            r_dout   <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_sel    <= w_sel_nxt;
            r_shadow <= w_shadow_nxt;
            r_dout   <= w_dout_nxt;
            r_valid  <= w_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_sel_nxt    = r_sel;
        w_shadow_nxt = r_shadow;
        w_dout_nxt   = r_dout;
        w_valid_nxt  = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_SETTLE;
                    w_sel_nxt   = '0;
                    w_cnt_nxt   = '0;
                end
            end
            ST_SETTLE: begin
                if (r_cnt == LP_CNT_LAST) begin
                    w_state_nxt = ST_SAMPLE;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            ST_SAMPLE: begin
                if (r_sel != 2'd3) begin
                    // channel 3 goes straight into dout, never via shadow
                    for (int i = 0; i < 3; i++) begin
                        if (r_sel == 2'(i)) begin
                            w_shadow_nxt[i] = y_in;
                        end
                    end
                    w_sel_nxt   = r_sel + 2'd1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_SETTLE;
                end else begin
                    w_dout_nxt  = {y_in, r_shadow};
                    w_valid_nxt = 1'b1;
                    w_sel_nxt   = '0;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (cont) begin
                    w_state_nxt = ST_SETTLE;
                    w_sel_nxt   = '0;
                    w_cnt_nxt   = '0;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign sel   = r_sel;
    assign busy  = (r_state != ST_IDLE);
    assign dout  = r_dout;
    assign valid = r_valid;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: two instances (settle 4 and settle 1)
// checked each cycle against a frame-time model plus literal points.
module tb_mux_scan_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic       cont;
    logic [3:0] x;
    logic       y0;
    logic       y1;
    logic [1:0] sel0;
    logic [1:0] sel1;
    logic       busy0;
    logic       busy1;
    logic [3:0] dout0;
    logic [3:0] dout1;
    logic       valid0;
    logic       valid1;

    int n_chk;
    int n_pass;
    int vcount0;

    mux_scan_ctrl #(.SETTLE_CYCLES(4)) u_dut0 (
        .clk(clk), .rst(rst), .start(start), .cont(cont), .y_in(y0),
        .sel(sel0), .busy(busy0), .dout(dout0), .valid(valid0)
    );

    mux_scan_ctrl #(.SETTLE_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .cont(cont), .y_in(y1),
        .sel(sel1), .busy(busy1), .dout(dout1), .valid(valid1)
    );

    // the 4:1 mux being scanned
    assign y0 = x[sel0];
    assign y1 = x[sel1];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // model: each frame is time t since the accepting edge;
    // period p = settle+1, channel c sampled at t=(c+1)p, done at t=4p
    bit         m_act[2];
    int         m_t[2];
    logic [3:0] m_samp[2];
    logic [3:0] m_dout[2];

    function automatic int period(int k);
        return (k == 0) ? 5 : 2;
    endfunction

    task automatic mstep(int k);
        int p;
        int f;
        p = period(k);
        f = 4 * p;
        if (rst) begin
            m_act[k]  = 1'b0;
            m_t[k]    = 0;
            m_dout[k] = 4'd0;
        end else if (m_act[k] && m_t[k] == f) begin
            if (cont) m_t[k] = 0;
            else m_act[k] = 1'b0;
        end else if (m_act[k]) begin
            m_t[k] = m_t[k] + 1;
            if (m_t[k] % p == 0) begin
                m_samp[k][m_t[k] / p - 1] = x[m_t[k] / p - 1];
                if (m_t[k] == f) m_dout[k] = m_samp[k];
            end
        end else if (start) begin
            m_act[k] = 1'b1;
            m_t[k]   = 0;
        end
    endtask

    function automatic logic [7:0] mexp(int k);
        int f;
        logic [1:0] s;
        logic v;
        f = 4 * period(k);
        s = (m_act[k] && m_t[k] < f) ? 2'(m_t[k] / period(k)) : 2'd0;
        v = m_act[k] && (m_t[k] == f);
        return {s, m_act[k], v, m_dout[k]};
    endfunction

    task automatic chk(string nm, logic [7:0] got, logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s t=%0t got sel/busy/valid/dout=%b/%b/%b/%b want %b/%b/%b/%b",
                     nm, $time, got[7:6], got[5], got[4], got[3:0],
                     exp[7:6], exp[5], exp[4], exp[3:0]);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [7:0] pk0();
        return {sel0, busy0, valid0, dout0};
    endfunction

    function automatic logic [7:0] pk1();
        return {sel1, busy1, valid1, dout1};
    endfunction

    always @(posedge clk) begin
        mstep(0);
        mstep(1);
        #1;
        chk("cycle_s4", pk0(), mexp(0));
        chk("cycle_s1", pk1(), mexp(1));
        if (valid0 === 1'b1) vcount0++;
    end

    task automatic edges(int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    int base;

    initial begin
        n_chk   = 0;
        n_pass  = 0;
        vcount0 = 0;
        rst     = 1'b1;
        start   = 1'b0;
        cont    = 1'b0;
        x       = 4'd0;
        edges(2);
        chk("reset_s4", pk0(), 8'b00_0_0_0000);
        chk("reset_s1", pk1(), 8'b00_0_0_0000);
        rst = 1'b0;
        edges(1);

        // single frame, x=1010
        x = 4'b1010;
        start = 1'b1;
        edges(1);
        start = 1'b0;
        chk("t1_e0", pk0(), 8'b00_1_0_0000);
        edges(5);
        chk("t1_e5_sel1", pk0(), 8'b01_1_0_0000);
        edges(15);
        chk("t1_e20_valid", pk0(), 8'b00_1_1_1010);
        edges(1);
        chk("t1_e21_idle", pk0(), 8'b00_0_0_1010);

        // idle hold, then second frame x=0110
        edges(3);
        chk("t2_hold", pk0(), 8'b00_0_0_1010);
        x = 4'b0110;
        start = 1'b1;
        edges(1);
        start = 1'b0;
        edges(20);
        chk("t2_e20_valid", pk0(), 8'b00_1_1_0110);
        edges(1);

        // continuous, x changes at edge 22
        x = 4'b0001;
        cont = 1'b1;
        start = 1'b1;
        edges(1);
        start = 1'b0;
        edges(20);
        chk("t3_e20_valid", pk0(), 8'b00_1_1_0001);
        edges(1);
        chk("t3_e21_busy", pk0(), 8'b00_1_0_0001);
        x = 4'b1000;
        edges(20);
        chk("t3_e41_valid", pk0(), 8'b00_1_1_1000);
        cont = 1'b0;
        edges(1);
        chk("t3_e42_idle", pk0(), 8'b00_0_0_1000);
        edges(12);

        // reset mid-scan at edge 10, restart at edge 12
        x = 4'b1100;
        start = 1'b1;
        edges(1);
        start = 1'b0;
        edges(9);
        rst = 1'b1;
        edges(1);
        chk("t4_e10_rst", pk0(), 8'b00_0_0_0000);
        rst = 1'b0;
        edges(1);
        x = 4'b0011;
        start = 1'b1;
        edges(1);
        start = 1'b0;
        edges(20);
        chk("t4_e32_valid", pk0(), 8'b00_1_1_0011);
        edges(1);

        // start pulses at edges 3 and 17 are ignored while busy
        base = vcount0;
        x = 4'b0101;
        start = 1'b1;
        edges(1);
        start = 1'b0;
        edges(2);
        start = 1'b1;
        edges(1);
        start = 1'b0;
        edges(13);
        start = 1'b1;
        edges(1);
        start = 1'b0;
        edges(3);
        chk("t5_e20_valid", pk0(), 8'b00_1_1_0101);
        edges(10);
        n_chk++;
        if (vcount0 - base != 1)
            $display("FAIL t5_pulses got %0d valid pulses want 1", vcount0 - base);
        else
            n_pass++;

        // settle=1 boundary
        x = 4'b1111;
        start = 1'b1;
        edges(1);
        start = 1'b0;
        edges(2);
        chk("t6_e2_sel1", pk1(), 8'b01_1_0_0101);
        edges(6);
        chk("t6_e8_valid", pk1(), 8'b00_1_1_1111);
        edges(25);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            rst   = ($urandom_range(0, 199) == 0);
            start = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 49) == 0) cont = ~cont;
            if ($urandom_range(0, 7) == 0) x = 4'($urandom);
            edges(1);
        end
        rst = 1'b0;
        start = 1'b0;
        edges(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mux_scan_ctrl.md
Name: mux_scan_ctrl

Overview:
Upstream sequencer for the 4:1 single-bit mux (mux_4_to_1).
- Drives the mux select, walking channels 0..3.
- Waits a programmable settle time on each channel, then samples the mux output.
- Assembles the four samples into a 4-bit word and presents it with a one-cycle valid pulse.
- Supports single-shot operation (start pulse) and continuous scanning.

Parameters:
SETTLE_CYCLES, 4, clock cycles spent in SETTLE per channel before sampling; legal range 1..255; counter width 8 bits.

Ports:
clk    input   1  system clock; all logic on rising edge
rst    input   1  synchronous, active-high reset
start  input   1  begin one scan; honoured only in IDLE
cont   input   1  continuous mode; sampled in DONE
y_in   input   1  mux output y; assumed synchronous to clk
sel    output  2  mux select, registered
busy   output  1  high in SETTLE, SAMPLE and DONE
dout   output  4  assembled word; dout[i] = y_in sampled while sel==i
valid  output  1  one-cycle pulse, high only in DONE

Behaviour:
- Reset: rst high at a clock edge forces state=IDLE, sel=0, cnt=0, shadow=0, dout=0, valid=0, busy=0. This applies from any state, including mid-scan; the partial scan is discarded and no valid is issued. Reset has priority over start and cont.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - sel=0, busy=0, valid=0, dout holds its last value.
  - start=1 at an edge: go to SETTLE with sel=0, cnt=0.
- SETTLE:
  - At each edge, if cnt==SETTLE_CYCLES-1, go to SAMPLE; otherwise cnt<=cnt+1.
  - Exactly SETTLE_CYCLES edges are spent in SETTLE.
- SAMPLE: one cycle. At the edge, shadow[sel]<=y_in.
  - If sel<3: sel<=sel+1, cnt<=0, go to SETTLE.
  - If sel==3: dout<={y_in, shadow[2:0]}, valid<=1, sel<=0, go to DONE.
- DONE: one cycle, valid=1, busy=1.
  - At the edge: valid<=0.
  - If cont=1: go to SETTLE with sel=0, cnt=0, starting the next frame back-to-back.
  - If cont=0: go to IDLE.
- Latency:
  - Channel i is sampled at edge (i+1)*(SETTLE_CYCLES+1), counting the start-accepting edge as edge 0.
  - valid is high in the cycle after edge 4*(SETTLE_CYCLES+1).
  - In continuous mode, consecutive valid pulses are 4*(SETTLE_CYCLES+1)+1 cycles apart.
- start while busy is ignored, with no queuing. start held high in IDLE re-triggers a scan on every return to IDLE.
- cont is examined only in DONE. Deasserting cont mid-scan lets the current frame complete; the block then returns to IDLE.
- y_in is not resynchronised inside the block. The settle interval absorbs mux propagation delay after each sel change.
- shadow is not cleared between frames; every bit is overwritten each frame.
- sel changes only on the transitions SAMPLE->SETTLE, SAMPLE->DONE, and into SETTLE from IDLE/DONE. It is glitch-free (registered).

Test Plan:
1. SETTLE_CYCLES=4, mux x=4'b1010, pulse start at edge 0.
   -> sel=0,1,2,3 during edges 1-5, 6-10, 11-15, 16-20; valid high for one cycle after edge 20; dout=4'b1010; busy falls after edge 21.
2. Single-shot with cont=0, then a second start after return to IDLE with x=4'b0110.
   -> second frame gives dout=4'b0110; dout holds 4'b1010 while idle between frames.
3. Continuous: cont=1, start at edge 0, x switches from 4'b0001 to 4'b1000 at edge 22.
   -> valid after edges 20 and 41; dout 4'b0001 then 4'b1000; busy never drops.
4. Reset mid-scan: start at edge 0, rst high at edge 10.
   -> after edge 10: sel=0, busy=0, dout=0, valid=0; no valid pulse appears; a new start at edge 12 runs a full frame with correct dout.
5. start re-asserted at edges 3 and 17 during a scan.
   -> ignored; exactly one valid pulse, still after edge 20.
6. Boundary SETTLE_CYCLES=1, x=4'b1111.
   -> sel advances every 2 cycles; valid after edge 8; dout=4'b1111.
